// File: rtl/branch_resolve_unit.sv
// Branch resolution for a two-stage predicted fetch path: carries the prediction
// bundle to s2, detects mispredicts, drives prediction-table updates and statistics.
module branch_resolve_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        valid_f,
  input  logic [31:0] pc4_f,
  input  logic        h_f,
  input  logic        p_f,
  input  logic [31:0] target_f,
  input  logic        is_beq_s2,
  input  logic        taken_s2,
  input  logic [31:0] baddr_in_s2,
  output logic [31:0] pc4_s2,
  output logic [31:0] baddr_s2,
  output logic        wrt,
  output logic        wrp,
  output logic        c,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  logic        valid_s1_q, valid_s2_q;
  logic [31:0] pc4_s1_q, pc4_s2_q;
  logic        h_s1_q, h_s2_q;
  logic        p_s1_q, p_s2_q;
  logic [31:0] target_s1_q, target_s2_q;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] mispred_cnt_q, mispred_cnt_d;

  logic res, pt, mispredict_raw, mispredict;

  assign res = valid_s2_q & is_beq_s2;
  assign pt  = h_s2_q & p_s2_q;

  // Non-BEQ with a taken prediction means the table entry aliased; fall through.
  assign mispredict_raw = (res & (pt != taken_s2))
                        | (res & pt & taken_s2 & (target_s2_q != baddr_in_s2))
                        | (valid_s2_q & ~is_beq_s2 & pt);
  assign mispredict = mispredict_raw & ~stall;

  assign redirect    = mispredict;
  assign flush       = mispredict;
  assign redirect_pc = (is_beq_s2 && taken_s2) ? baddr_in_s2 : pc4_s2_q;

  assign wrt      = res & ~h_s2_q & ~stall;
  assign wrp      = res & (~h_s2_q | (p_s2_q != taken_s2)) & ~stall;
  assign c        = taken_s2;
  assign pc4_s2   = pc4_s2_q;
  assign baddr_s2 = baddr_in_s2;

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res && !stall && branch_cnt_q != 16'hFFFF)
      branch_cnt_d = branch_cnt_q + 16'd1;
    if (mispredict && mispred_cnt_q != 16'hFFFF)
      mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  // flush can only be high when unstalled, so it rides the normal advance path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_s1_q    <= 1'b0;
      pc4_s1_q      <= '0;
      h_s1_q        <= 1'b0;
      p_s1_q        <= 1'b0;
      target_s1_q   <= '0;
      valid_s2_q    <= 1'b0;
      pc4_s2_q      <= '0;
      h_s2_q        <= 1'b0;
      p_s2_q        <= 1'b0;
      target_s2_q   <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (!stall) begin
        valid_s1_q  <= valid_f & ~flush;
        pc4_s1_q    <= pc4_f;
        h_s1_q      <= h_f;
        p_s1_q      <= p_f;
        target_s1_q <= target_f;
        valid_s2_q  <= valid_s1_q & ~flush;
        pc4_s2_q    <= pc4_s1_q;
        h_s2_q      <= h_s1_q;
        p_s2_q      <= p_s1_q;
        target_s2_q <= target_s1_q;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors checked with
// immediate assertions, including stall, saturation and asynchronous reset.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        valid_f;
  logic [31:0] pc4_f;
  logic        h_f;
  logic        p_f;
  logic [31:0] target_f;
  logic        is_beq_s2;
  logic        taken_s2;
  logic [31:0] baddr_in_s2;
  logic [31:0] pc4_s2;
  logic [31:0] baddr_s2;
  logic        wrt;
  logic        wrp;
  logic        c;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int vectors = 0;
  int errors  = 0;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .valid_f(valid_f), .pc4_f(pc4_f), .h_f(h_f), .p_f(p_f), .target_f(target_f),
    .is_beq_s2(is_beq_s2), .taken_s2(taken_s2), .baddr_in_s2(baddr_in_s2),
    .pc4_s2(pc4_s2), .baddr_s2(baddr_s2), .wrt(wrt), .wrp(wrp), .c(c),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic h,
                       input logic p, input logic [31:0] tgt);
    valid_f  = v;
    pc4_f    = pc;
    h_f      = h;
    p_f      = p;
    target_f = tgt;
  endtask

  task automatic resolve(input logic beq, input logic tk, input logic [31:0] ba);
    is_beq_s2   = beq;
    taken_s2    = tk;
    baddr_in_s2 = ba;
    #1;
  endtask

  task automatic counts(input string tag, input logic [15:0] bc, input logic [15:0] mc);
    check({tag, "_bcnt"}, {16'd0, branch_count}, {16'd0, bc});
    check({tag, "_mcnt"}, {16'd0, mispredict_count}, {16'd0, mc});
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    resolve(1'b0, 1'b0, 32'h0);
    repeat (3) tick();

    // reset state
    check("rst_wrt", {31'd0, wrt}, 32'd0);
    check("rst_wrp", {31'd0, wrp}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_c", {31'd0, c}, 32'd0);
    check("rst_pc4", pc4_s2, 32'd0);
    counts("rst", 16'd0, 16'd0);
    rst = 1'b0;
    tick();

    // cold miss
    fetch(1'b1, 32'h104, 1'b0, 1'b0, 32'h0); tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);   tick();
    resolve(1'b1, 1'b1, 32'h200);
    check("cold_wrt", {31'd0, wrt}, 32'd1);
    check("cold_wrp", {31'd0, wrp}, 32'd1);
    check("cold_c", {31'd0, c}, 32'd1);
    check("cold_flush", {31'd0, flush}, 32'd1);
    check("cold_redirect", {31'd0, redirect}, 32'd1);
    check("cold_rpc", redirect_pc, 32'h200);
    check("cold_pc4", pc4_s2, 32'h104);
    check("cold_baddr", baddr_s2, 32'h200);
    tick();
    counts("cold", 16'd1, 16'd1);
    check("cold_after_redirect", {31'd0, redirect}, 32'd0);
    resolve(1'b0, 1'b0, 32'h0);

    // correct hit
    fetch(1'b1, 32'h104, 1'b1, 1'b1, 32'h200); tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);     tick();
    resolve(1'b1, 1'b1, 32'h200);
    check("hit_wrt", {31'd0, wrt}, 32'd0);
    check("hit_wrp", {31'd0, wrp}, 32'd0);
    check("hit_redirect", {31'd0, redirect}, 32'd0);
    tick();
    counts("hit", 16'd2, 16'd1);
    resolve(1'b0, 1'b0, 32'h0);

    // wrong target on a taken hit
    fetch(1'b1, 32'h140, 1'b1, 1'b1, 32'h200); tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);     tick();
    resolve(1'b1, 1'b1, 32'h280);
    check("tgt_redirect", {31'd0, redirect}, 32'd1);
    check("tgt_wrp", {31'd0, wrp}, 32'd0);
    check("tgt_rpc", redirect_pc, 32'h280);
    tick();
    counts("tgt", 16'd3, 16'd2);
    resolve(1'b0, 1'b0, 32'h0);

    // aliased entry on a non-branch
    fetch(1'b1, 32'h150, 1'b1, 1'b1, 32'h300); tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);     tick();
    resolve(1'b0, 1'b0, 32'h0);
    check("alias_flush", {31'd0, flush}, 32'd1);
    check("alias_wrt", {31'd0, wrt}, 32'd0);
    check("alias_rpc", redirect_pc, 32'h150);
    tick();
    counts("alias", 16'd3, 16'd3);

    // wrong direction, younger instructions in s1 and fetch get squashed
    fetch(1'b1, 32'h108, 1'b1, 1'b1, 32'h200); tick();
    fetch(1'b1, 32'h10C, 1'b0, 1'b0, 32'h0);   tick();
    fetch(1'b1, 32'h110, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b0, 32'h200);
    check("dir_wrt", {31'd0, wrt}, 32'd0);
    check("dir_wrp", {31'd0, wrp}, 32'd1);
    check("dir_c", {31'd0, c}, 32'd0);
    check("dir_flush", {31'd0, flush}, 32'd1);
    check("dir_rpc", redirect_pc, 32'h108);
    tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    counts("dir", 16'd4, 16'd4);
    // s2 now holds the squashed 0x10C (h=0): a valid BEQ there would strobe wrt
    resolve(1'b1, 1'b1, 32'h0);
    check("dir_s2_clear", {31'd0, wrt}, 32'd0);
    tick();
    check("dir_s1_clear", {31'd0, wrt}, 32'd0);
    check("dir_s1_clear_redirect", {31'd0, redirect}, 32'd0);
    tick();
    counts("dir_post", 16'd4, 16'd4);
    resolve(1'b0, 1'b0, 32'h0);

    // stall with a mispredicting BEQ in s2
    fetch(1'b1, 32'h120, 1'b0, 1'b0, 32'h0); tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);   tick();
    stall = 1'b1;
    resolve(1'b1, 1'b1, 32'h400);
    for (int i = 0; i < 3; i++) begin
      check("stall_wrt", {31'd0, wrt}, 32'd0);
      check("stall_wrp", {31'd0, wrp}, 32'd0);
      check("stall_flush", {31'd0, flush}, 32'd0);
      tick();
      counts("stall", 16'd4, 16'd4);
    end
    stall = 1'b0;
    #1;
    check("unstall_wrt", {31'd0, wrt}, 32'd1);
    check("unstall_redirect", {31'd0, redirect}, 32'd1);
    check("unstall_rpc", redirect_pc, 32'h400);
    check("unstall_pc4", pc4_s2, 32'h120);
    tick();
    counts("unstall", 16'd5, 16'd5);
    check("unstall_once", {31'd0, wrt}, 32'd0);
    resolve(1'b0, 1'b0, 32'h0);

    // saturation: stream correctly predicted BEQs
    fetch(1'b1, 32'h104, 1'b1, 1'b1, 32'h200); tick(); tick();
    resolve(1'b1, 1'b1, 32'h200);
    repeat (16'hFFFE - 16'd5) tick();
    counts("sat_pre", 16'hFFFE, 16'd5);
    tick();
    counts("sat_1", 16'hFFFF, 16'd5);
    tick(); tick();
    counts("sat_3", 16'hFFFF, 16'd5);
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    resolve(1'b0, 1'b0, 32'h0);
    tick(); tick();

    // asynchronous reset in the middle of a flush
    fetch(1'b1, 32'h104, 1'b0, 1'b0, 32'h0); tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);   tick();
    resolve(1'b1, 1'b1, 32'h200);
    check("arst_pre_flush", {31'd0, flush}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wrt", {31'd0, wrt}, 32'd0);
    check("arst_wrp", {31'd0, wrp}, 32'd0);
    check("arst_flush", {31'd0, flush}, 32'd0);
    check("arst_pc4", pc4_s2, 32'd0);
    counts("arst", 16'd0, 16'd0);
    resolve(1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    fetch(1'b1, 32'h104, 1'b0, 1'b0, 32'h0); tick();
    fetch(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);   tick();
    resolve(1'b1, 1'b1, 32'h200);
    check("cold2_wrt", {31'd0, wrt}, 32'd1);
    check("cold2_wrp", {31'd0, wrp}, 32'd1);
    check("cold2_rpc", redirect_pc, 32'h200);
    tick();
    counts("cold2", 16'd1, 16'd1);
    resolve(1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
